exe_mem_stage: RTL and testbench

//   EXE stage plus EXE/MEM pipeline register. Consumes the ID/EXE register outputs,

---
 rtl/exe_mem_stage.sv | 173 +++++++++++++++++
 tb/tb_exe_mem_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_stage.sv
// EXE stage and EXE/MEM pipeline register.
// The block picks the ALU operands and computes the ALU result combinationally.
// The result is also driven out as a same-cycle forwarding tap. On each clock
// edge the result and the MEM/WB controls are registered into the MEM stage.
// Flush takes priority over stall. A bubble never carries write enables forward.
module exe_mem_stage #(
  parameter int unsigned DW   = 32,
  parameter int unsigned RNW  = 5,
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            clrn,
  // ID/EXE register outputs
  input  logic            exe_valid,
  input  logic            exe_m2reg,
  input  logic            exe_wmem,
  input  logic            exe_wreg,
  input  logic [2:0]      exe_aluc,
  input  logic            exe_aluimm,
  input  logic            exe_shift,
  input  logic [DW-1:0]   exe_ra,
  input  logic [DW-1:0]   exe_rb,
  input  logic [DW-1:0]   exe_imm,
  input  logic [RNW-1:0]  exe_rn,
  // MEM-side flow control
  input  logic            mem_stall,
  input  logic            mem_flush,
  output logic            exe_ready,
  // forwarding tap
  output logic [DW-1:0]   exe_fwd_alu,
  output logic            exe_fwd_wr,
  // EXE/MEM register
  output logic            mem_valid,
  output logic            mem_m2reg,
  output logic            mem_wmem,
  output logic            mem_wreg,
  output logic [DW-1:0]   mem_alu,
  output logic [DW-1:0]   mem_rb,
  output logic [RNW-1:0]  mem_rn,
  output logic            mem_zero,
  output logic [CNTW-1:0] inst_count
);

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluXor = 3'b100,
    AluSll = 3'b101,
    AluSrl = 3'b110,
    AluSra = 3'b111
  } alu_op_e;

  logic [DW-1:0] opa, opb, alu_res;
  logic [4:0]    shamt;
  alu_op_e       alu_op;

  // State registers with their next-state values
  logic            valid_q,  valid_d;
  logic            m2reg_q,  m2reg_d;
  logic            wmem_q,   wmem_d;
  logic            wreg_q,   wreg_d;
  logic [DW-1:0]   alu_q,    alu_d;
  logic [DW-1:0]   rb_q,     rb_d;
  logic [RNW-1:0]  rn_q,     rn_d;
  logic            zero_q,   zero_d;
  logic [CNTW-1:0] count_q,  count_d;

  // Operand selection; the shift amount comes from the immediate's shamt field
  always_comb begin
    opa = exe_shift ? {{(DW-5){1'b0}}, exe_imm[10:6]} : exe_ra;
    opb = exe_aluimm ? exe_imm : exe_rb;
  end

  assign shamt  = opa[4:0];
  assign alu_op = alu_op_e'(exe_aluc);

  // ALU; shifts move operand B by A[4:0], arithmetic add/sub wrap silently
  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      AluAdd: alu_res = opa + opb;
      AluSub: alu_res = opa - opb;
      AluAnd: alu_res = opa & opb;
      AluOr:  alu_res = opa | opb;
      AluXor: alu_res = opa ^ opb;
      AluSll: alu_res = opb << shamt;
      AluSrl: alu_res = opb >> shamt;
      AluSra: alu_res = $unsigned($signed(opb) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Combinational outputs toward ID and the forwarding network
  always_comb begin
    exe_ready   = ~mem_stall | mem_flush;
    exe_fwd_alu = alu_res;
    // Loads are excluded: their data is not known until MEM
    exe_fwd_wr  = exe_valid & exe_wreg & ~exe_m2reg & (exe_rn != '0);
  end

  // Next-state for the EXE/MEM register: flush, then stall, then load
  always_comb begin
    valid_d = valid_q;
    m2reg_d = m2reg_q;
    wmem_d  = wmem_q;
    wreg_d  = wreg_q;
    alu_d   = alu_q;
    rb_d    = rb_q;
    rn_d    = rn_q;
    zero_d  = zero_q;
    count_d = count_q;
    if (mem_flush) begin
      // Data fields hold; only the valid bit and the side-effect controls drop
      valid_d = 1'b0;
      m2reg_d = 1'b0;
      wmem_d  = 1'b0;
      wreg_d  = 1'b0;
    end else if (!mem_stall) begin
      valid_d = exe_valid;
      m2reg_d = exe_valid & exe_m2reg;
      wmem_d  = exe_valid & exe_wmem;
      wreg_d  = exe_valid & exe_wreg;
      alu_d   = alu_res;
      rb_d    = exe_rb;
      rn_d    = exe_rn;
      zero_d  = (alu_res == '0);
      if (exe_valid) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // EXE/MEM register with asynchronous clear
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= 1'b0;
      m2reg_q <= 1'b0;
      wmem_q  <= 1'b0;
      wreg_q  <= 1'b0;
      alu_q   <= '0;
      rb_q    <= '0;
      rn_q    <= '0;
      zero_q  <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      m2reg_q <= m2reg_d;
      wmem_q  <= wmem_d;
      wreg_q  <= wreg_d;
      alu_q   <= alu_d;
      rb_q    <= rb_d;
      rn_q    <= rn_d;
      zero_q  <= zero_d;
      count_q <= count_d;
    end
  end

  // Registered outputs
  always_comb begin
    mem_valid  = valid_q;
    mem_m2reg  = m2reg_q;
    mem_wmem   = wmem_q;
    mem_wreg   = wreg_q;
    mem_alu    = alu_q;
    mem_rb     = rb_q;
    mem_rn     = rn_q;
    mem_zero   = zero_q;
    inst_count = count_q;
  end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed bench for exe_mem_stage. The counter is narrowed to 4 bits so that
// the wrap from all-ones to zero can be reached in a few cycles.
module tb_exe_mem_stage;

  localparam int unsigned DW   = 32;
  localparam int unsigned RNW  = 5;
  localparam int unsigned CNTW = 4;

  logic            clk = 1'b0;
  logic            clrn;
  logic            exe_valid, exe_m2reg, exe_wmem, exe_wreg;
  logic [2:0]      exe_aluc;
  logic            exe_aluimm, exe_shift;
  logic [DW-1:0]   exe_ra, exe_rb, exe_imm;
  logic [RNW-1:0]  exe_rn;
  logic            mem_stall, mem_flush;
  logic            exe_ready;
  logic [DW-1:0]   exe_fwd_alu;
  logic            exe_fwd_wr;
  logic            mem_valid, mem_m2reg, mem_wmem, mem_wreg;
  logic [DW-1:0]   mem_alu, mem_rb;
  logic [RNW-1:0]  mem_rn;
  logic            mem_zero;
  logic [CNTW-1:0] inst_count;

  int vectors    = 0;
  int miscompares = 0;

  exe_mem_stage #(.DW(DW), .RNW(RNW), .CNTW(CNTW)) dut (
    .clk(clk), .clrn(clrn),
    .exe_valid(exe_valid), .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem), .exe_wreg(exe_wreg),
    .exe_aluc(exe_aluc), .exe_aluimm(exe_aluimm), .exe_shift(exe_shift),
    .exe_ra(exe_ra), .exe_rb(exe_rb), .exe_imm(exe_imm), .exe_rn(exe_rn),
    .mem_stall(mem_stall), .mem_flush(mem_flush), .exe_ready(exe_ready),
    .exe_fwd_alu(exe_fwd_alu), .exe_fwd_wr(exe_fwd_wr),
    .mem_valid(mem_valid), .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem), .mem_wreg(mem_wreg),
    .mem_alu(mem_alu), .mem_rb(mem_rb), .mem_rn(mem_rn), .mem_zero(mem_zero),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [2:0] op, input logic [DW-1:0] ra,
                        input logic [DW-1:0] rb, input logic [DW-1:0] imm,
                        input logic aimm, input logic sh);
    exe_valid  = v;
    exe_aluc   = op;
    exe_ra     = ra;
    exe_rb     = rb;
    exe_imm    = imm;
    exe_aluimm = aimm;
    exe_shift  = sh;
  endtask

  initial begin
    clrn = 1'b0;
    exe_m2reg = 1'b0; exe_wmem = 1'b0; exe_wreg = 1'b0; exe_rn = '0;
    mem_stall = 1'b0; mem_flush = 1'b0;
    set_op(1'b0, 3'b000, '0, '0, '0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_alu",   mem_alu, 32'd0);
    chk("rst_count", {28'b0, inst_count}, 32'd0);
    chk("rst_ready", {31'b0, exe_ready}, 32'd1);
    clrn = 1'b1;

    // ADD ra + imm(-1) = 4
    set_op(1'b1, 3'b000, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    exe_wreg = 1'b1; exe_rn = 5'd3;
    #1;
    chk("add_fwd_alu", exe_fwd_alu, 32'd4);
    chk("add_fwd_wr",  {31'b0, exe_fwd_wr}, 32'd1);
    tick();
    chk("add_alu",   mem_alu, 32'd4);
    chk("add_zero",  {31'b0, mem_zero}, 32'd0);
    chk("add_valid", {31'b0, mem_valid}, 32'd1);
    chk("add_wreg",  {31'b0, mem_wreg}, 32'd1);
    chk("add_rn",    {27'b0, mem_rn}, 32'd3);
    chk("add_count", {28'b0, inst_count}, 32'd1);

    // SRA by shamt 4 from imm[10:6], r0 destination passes through
    set_op(1'b1, 3'b111, 32'd0, 32'h8000_0000, 32'h0000_0100, 1'b0, 1'b1);
    exe_rn = 5'd0;
    #1;
    chk("sra_fwd_wr_r0", {31'b0, exe_fwd_wr}, 32'd0);
    tick();
    chk("sra_alu",   mem_alu, 32'hF800_0000);
    chk("sra_rb",    mem_rb, 32'h8000_0000);
    chk("sra_rn",    {27'b0, mem_rn}, 32'd0);
    chk("sra_wreg",  {31'b0, mem_wreg}, 32'd1);
    chk("sra_count", {28'b0, inst_count}, 32'd2);

    // SUB 7-7 store: zero flag set
    set_op(1'b1, 3'b001, 32'd7, 32'd7, 32'd0, 1'b0, 1'b0);
    exe_wmem = 1'b1; exe_wreg = 1'b0; exe_rn = 5'd4;
    tick();
    chk("sub_alu",   mem_alu, 32'd0);
    chk("sub_zero",  {31'b0, mem_zero}, 32'd1);
    chk("sub_wmem",  {31'b0, mem_wmem}, 32'd1);
    chk("sub_wreg",  {31'b0, mem_wreg}, 32'd0);
    chk("sub_count", {28'b0, inst_count}, 32'd3);

    // Bubble with controls set: data loads, controls gated, count holds
    set_op(1'b0, 3'b010, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 1'b0);
    exe_wmem = 1'b1; exe_wreg = 1'b1;
    #1;
    chk("bub_fwd_wr", {31'b0, exe_fwd_wr}, 32'd0);
    tick();
    chk("bub_alu",   mem_alu, 32'h0000_F000);
    chk("bub_valid", {31'b0, mem_valid}, 32'd0);
    chk("bub_wreg",  {31'b0, mem_wreg}, 32'd0);
    chk("bub_wmem",  {31'b0, mem_wmem}, 32'd0);
    chk("bub_count", {28'b0, inst_count}, 32'd3);

    // Load instruction held off by a 3-cycle stall
    set_op(1'b1, 3'b000, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
    exe_wmem = 1'b0; exe_wreg = 1'b1; exe_m2reg = 1'b1; exe_rn = 5'd9;
    mem_stall = 1'b1;
    #1;
    chk("stl_ready",  {31'b0, exe_ready}, 32'd0);
    chk("stl_fwd_wr", {31'b0, exe_fwd_wr}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_alu",   mem_alu, 32'h0000_F000);
      chk("stl_valid", {31'b0, mem_valid}, 32'd0);
      chk("stl_count", {28'b0, inst_count}, 32'd3);
    end
    mem_stall = 1'b0;
    tick();
    chk("rel_alu",   mem_alu, 32'd3);
    chk("rel_m2reg", {31'b0, mem_m2reg}, 32'd1);
    chk("rel_rn",    {27'b0, mem_rn}, 32'd9);
    chk("rel_valid", {31'b0, mem_valid}, 32'd1);
    chk("rel_count", {28'b0, inst_count}, 32'd4);

    // Stall and flush together: flush wins, data holds, count holds
    set_op(1'b1, 3'b011, 32'h0000_000F, 32'h0000_00F0, 32'd0, 1'b0, 1'b0);
    exe_m2reg = 1'b0; exe_wmem = 1'b1; exe_wreg = 1'b1;
    mem_stall = 1'b1; mem_flush = 1'b1;
    #1;
    chk("fl_ready", {31'b0, exe_ready}, 32'd1);
    chk("or_fwd",   exe_fwd_alu, 32'h0000_00FF);
    tick();
    chk("fl_valid", {31'b0, mem_valid}, 32'd0);
    chk("fl_wreg",  {31'b0, mem_wreg}, 32'd0);
    chk("fl_wmem",  {31'b0, mem_wmem}, 32'd0);
    chk("fl_m2reg", {31'b0, mem_m2reg}, 32'd0);
    chk("fl_alu",   mem_alu, 32'd3);
    chk("fl_count", {28'b0, inst_count}, 32'd4);
    mem_stall = 1'b0; mem_flush = 1'b0;
    exe_wmem = 1'b0;

    // SLL 1 by 8
    set_op(1'b1, 3'b101, 32'd0, 32'd1, 32'h0000_0200, 1'b0, 1'b1);
    tick();
    chk("sll_alu", mem_alu, 32'h0000_0100);
    // SRL 0x80000000 by 4
    set_op(1'b1, 3'b110, 32'd0, 32'h8000_0000, 32'h0000_0100, 1'b0, 1'b1);
    tick();
    chk("srl_alu", mem_alu, 32'h0800_0000);
    // XOR
    set_op(1'b1, 3'b100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 1'b0, 1'b0);
    tick();
    chk("xor_alu",   mem_alu, 32'hF0F0_0F0F);
    chk("xor_count", {28'b0, inst_count}, 32'd7);

    // Run the counter up to all-ones, then wrap
    set_op(1'b1, 3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("cnt_max", {28'b0, inst_count}, 32'd15);
    exe_valid = 1'b0;
    tick();
    chk("cnt_bubble_hold", {28'b0, inst_count}, 32'd15);
    exe_valid = 1'b1;
    tick();
    chk("cnt_wrap", {28'b0, inst_count}, 32'd0);
    chk("pre_rst_valid", {31'b0, mem_valid}, 32'd1);

    // Asynchronous reset mid-cycle, observed before the next rising edge
    #3 clrn = 1'b0;
    #1;
    chk("arst_valid", {31'b0, mem_valid}, 32'd0);
    chk("arst_wreg",  {31'b0, mem_wreg}, 32'd0);
    chk("arst_alu",   mem_alu, 32'd0);
    chk("arst_rn",    {27'b0, mem_rn}, 32'd0);
    chk("arst_count", {28'b0, inst_count}, 32'd0);
    exe_valid = 1'b0;
    tick();
    clrn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
